// File: rtl/stream_mux_arb.sv
// stream_mux_arb: N-channel valid/ready stream multiplexer with a registered output stage,
// fixed select (MODE 0) or round-robin (MODE 1). Define STREAM_MUX_ARB_LAST_EN for packet locking.
module stream_mux_arb #(
  parameter int WIDTH = 32,
  parameter int N     = 8,
  parameter int SEL_W = 3,
  parameter int MODE  = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [SEL_W-1:0]   sel,
  input  logic [N-1:0]       in_valid,
  output logic [N-1:0]       in_ready,
  input  logic [N*WIDTH-1:0] in_data,
`ifdef STREAM_MUX_ARB_LAST_EN
  input  logic [N-1:0]       in_last,
  output logic               out_last,
`endif
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic [SEL_W-1:0]   out_id
);

  logic             load;
  logic             grant_vld;
  logic [SEL_W-1:0] grant;
  logic [WIDTH-1:0] grant_data;
  logic             xfer;
  logic             xfer_last;
  logic [SEL_W-1:0] rr_ptr;
  logic [SEL_W-1:0] rr_grant;
  logic             rr_found;

`ifdef STREAM_MUX_ARB_LAST_EN
  logic             locked;
  logic [SEL_W-1:0] lock_id;
`endif

  function automatic int rr_idx(input logic [SEL_W-1:0] base, input int k);
    int s;
    s = int'(base) + k;
    return (s >= N) ? s - N : s;
  endfunction

  // Reset also blocks acceptance so no upstream beat is consumed and then discarded.
  assign load = !rst && (!out_valid || out_ready);

  // NOTE: every variable written in always_comb gets a default first, so no path infers a latch.
  always_comb begin
    rr_found = 1'b0;
    rr_grant = '0;
    for (int k = 0; k < N; k++) begin
      if (!rr_found && in_valid[rr_idx(rr_ptr, k)]) begin
        rr_found = 1'b1;
        rr_grant = SEL_W'(rr_idx(rr_ptr, k));
      end
    end
  end

  always_comb begin
    grant     = '0;
    grant_vld = 1'b0;
    if (MODE == 0) begin
      grant     = sel;
      grant_vld = (int'(sel) < N);
    end else begin
      grant     = rr_grant;
      grant_vld = rr_found;
    end
`ifdef STREAM_MUX_ARB_LAST_EN
    if (locked) begin
      grant     = lock_id;
      grant_vld = 1'b1;
    end
`endif
  end

  always_comb begin
    in_ready   = '0;
    grant_data = '0;
    for (int i = 0; i < N; i++) begin
      if (grant == SEL_W'(i)) begin
        in_ready[i] = load && grant_vld;
        grant_data  = in_data[i*WIDTH +: WIDTH];
      end
    end
  end

  assign xfer = |(in_valid & in_ready);

`ifdef STREAM_MUX_ARB_LAST_EN
  assign xfer_last = |(in_valid & in_ready & in_last);
`else
  // Without packet framing every beat is its own packet.
  assign xfer_last = 1'b1;
`endif

  // NOTE: sequential state uses non-blocking assignments so all registers update from the same pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_id    <= '0;
      rr_ptr    <= '0;
    end else begin
      if (load) out_valid <= xfer;
      if (xfer) begin
        out_data <= grant_data;
        out_id   <= grant;
      end
      if (MODE != 0 && xfer && xfer_last)
        rr_ptr <= (grant == SEL_W'(N - 1)) ? '0 : grant + 1'b1;
    end
  end

`ifdef STREAM_MUX_ARB_LAST_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      locked   <= 1'b0;
      lock_id  <= '0;
      out_last <= 1'b0;
    end else if (xfer) begin
      out_last <= xfer_last;
      locked   <= !xfer_last;
      lock_id  <= grant;
    end
  end
`endif

endmodule

// File: tb/tb_stream_mux_arb.sv
// Directed bench for stream_mux_arb: one fixed-select instance (SEL_W=4) and one round-robin instance.
module tb_stream_mux_arb;

  logic         clk = 1'b0;
  logic         rst;
  int           checks = 0;
  int           errors = 0;

  logic [3:0]   sel0;
  logic [7:0]   v0, r0;
  logic [255:0] d0;
  logic         or0, ov0;
  logic [31:0]  od0;
  logic [3:0]   oid0;

  logic [2:0]   sel1;
  logic [7:0]   v1, r1;
  logic [255:0] d1;
  logic         or1, ov1;
  logic [31:0]  od1;
  logic [2:0]   oid1;

`ifdef STREAM_MUX_ARB_LAST_EN
  logic [7:0]   l0, l1;
  logic         ol0, ol1;
`endif

  always #5 clk = ~clk;

  stream_mux_arb #(.WIDTH(32), .N(8), .SEL_W(4), .MODE(0)) u0 (
    .clk(clk), .rst(rst), .sel(sel0), .in_valid(v0), .in_ready(r0), .in_data(d0),
`ifdef STREAM_MUX_ARB_LAST_EN
    .in_last(l0), .out_last(ol0),
`endif
    .out_valid(ov0), .out_ready(or0), .out_data(od0), .out_id(oid0)
  );

  stream_mux_arb #(.WIDTH(32), .N(8), .SEL_W(3), .MODE(1)) u1 (
    .clk(clk), .rst(rst), .sel(sel1), .in_valid(v1), .in_ready(r1), .in_data(d1),
`ifdef STREAM_MUX_ARB_LAST_EN
    .in_last(l1), .out_last(ol1),
`endif
    .out_valid(ov1), .out_ready(or1), .out_data(od1), .out_id(oid1)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; sel0 = 4'd5; sel1 = 3'd0;
    v0 = 8'hFF; v1 = 8'hFF; or0 = 1'b1; or1 = 1'b1;
    step(); step();
    checks++; if (ov0 !== 1'b0) begin errors++; $display("FAIL reset_ov0 got %b want 0", ov0); end
    checks++; if (od0 !== 32'h0) begin errors++; $display("FAIL reset_od0 got %h want 0", od0); end
    checks++; if (oid0 !== 4'd0) begin errors++; $display("FAIL reset_oid0 got %0d want 0", oid0); end
    checks++; if (r0 !== 8'h00) begin errors++; $display("FAIL reset_r0 got %h want 00", r0); end
    checks++; if (ov1 !== 1'b0) begin errors++; $display("FAIL reset_ov1 got %b want 0", ov1); end
    checks++; if (od1 !== 32'h0) begin errors++; $display("FAIL reset_od1 got %h want 0", od1); end
    checks++; if (oid1 !== 3'd0) begin errors++; $display("FAIL reset_oid1 got %0d want 0", oid1); end
    checks++; if (r1 !== 8'h00) begin errors++; $display("FAIL reset_r1 got %h want 00", r1); end
    rst = 1'b0; v1 = 8'h00;
  endtask

  task automatic test_mode0();
    #1;
    checks++; if (r0 !== 8'h20) begin errors++; $display("FAIL m0_ready_sel5 got %h want 20", r0); end
    step();
    checks++; if (od0 !== 32'hA5) begin errors++; $display("FAIL m0_data_sel5 got %h want a5", od0); end
    checks++; if (oid0 !== 4'd5) begin errors++; $display("FAIL m0_id_sel5 got %0d want 5", oid0); end
    checks++; if (ov0 !== 1'b1) begin errors++; $display("FAIL m0_valid_sel5 got %b want 1", ov0); end
    sel0 = 4'd9; #1;
    checks++; if (r0 !== 8'h00) begin errors++; $display("FAIL m0_ready_sel9 got %h want 00", r0); end
    step();
    checks++; if (ov0 !== 1'b0) begin errors++; $display("FAIL m0_valid_sel9 got %b want 0", ov0); end
    checks++; if (od0 !== 32'hA5) begin errors++; $display("FAIL m0_hold_data got %h want a5", od0); end
    checks++; if (oid0 !== 4'd5) begin errors++; $display("FAIL m0_hold_id got %0d want 5", oid0); end
    sel0 = 4'd2; #1;
    checks++; if (r0 !== 8'h04) begin errors++; $display("FAIL m0_ready_sel2 got %h want 04", r0); end
    step();
    checks++; if (od0 !== 32'hA2) begin errors++; $display("FAIL m0_data_sel2 got %h want a2", od0); end
    checks++; if (oid0 !== 4'd2) begin errors++; $display("FAIL m0_id_sel2 got %0d want 2", oid0); end
  endtask

  task automatic test_fairness();
    logic [2:0] exp_id;
    v1 = 8'hFF; or1 = 1'b1;
    for (int k = 0; k < 10; k++) begin
      step();
      exp_id = 3'(k % 8);
      checks++; if (oid1 !== exp_id || ov1 !== 1'b1)
        begin errors++; $display("FAIL rr_all_id[%0d] got %0d/v%b want %0d/v1", k, oid1, ov1, exp_id); end
      checks++; if (od1 !== 32'hB0 + 32'(exp_id))
        begin errors++; $display("FAIL rr_all_data[%0d] got %h want %h", k, od1, 32'hB0 + 32'(exp_id)); end
    end
    v1 = 8'h44;
    for (int k = 0; k < 4; k++) begin
      step();
      exp_id = (k % 2 == 0) ? 3'd2 : 3'd6;
      checks++; if (oid1 !== exp_id)
        begin errors++; $display("FAIL rr_pair_id[%0d] got %0d want %0d", k, oid1, exp_id); end
    end
  endtask

  task automatic test_backpressure();
    v1 = 8'hFF; or1 = 1'b0;
    for (int k = 0; k < 4; k++) begin
      #1;
      checks++; if (r1 !== 8'h00) begin errors++; $display("FAIL bp_ready[%0d] got %h want 00", k, r1); end
      step();
      checks++; if (oid1 !== 3'd6 || od1 !== 32'hB6 || ov1 !== 1'b1)
        begin errors++; $display("FAIL bp_hold[%0d] got id%0d %h v%b want id6 b6 v1", k, oid1, od1, ov1); end
    end
    or1 = 1'b1; #1;
    checks++; if (r1 !== 8'h80) begin errors++; $display("FAIL bp_release_ready got %h want 80", r1); end
    step();
    checks++; if (oid1 !== 3'd7 || od1 !== 32'hB7)
      begin errors++; $display("FAIL bp_next got id%0d %h want id7 b7", oid1, od1); end
    step();
    checks++; if (oid1 !== 3'd0 || od1 !== 32'hB0)
      begin errors++; $display("FAIL bp_wrap got id%0d %h want id0 b0", oid1, od1); end
  endtask

  task automatic test_bubble();
    v1 = 8'h00;
    for (int k = 0; k < 3; k++) begin
      step();
      checks++; if (ov1 !== 1'b0 || oid1 !== 3'd0 || od1 !== 32'hB0)
        begin errors++; $display("FAIL bubble[%0d] got v%b id%0d %h want v0 id0 b0", k, ov1, oid1, od1); end
    end
    v1 = 8'hFF; #1;
    checks++; if (r1 !== 8'h02) begin errors++; $display("FAIL bubble_ptr_ready got %h want 02", r1); end
    step();
    checks++; if (oid1 !== 3'd1 || ov1 !== 1'b1)
      begin errors++; $display("FAIL bubble_resume got id%0d v%b want id1 v1", oid1, ov1); end
    v1 = 8'h00;
  endtask

`ifdef STREAM_MUX_ARB_LAST_EN
  task automatic test_last();
    // Fixed-select instance: lock on channel 3 survives a select change.
    sel0 = 4'd3; l0 = 8'hF7;
    step();
    checks++; if (oid0 !== 4'd3 || ol0 !== 1'b0)
      begin errors++; $display("FAIL m0_lock_b1 got id%0d l%b want id3 l0", oid0, ol0); end
    sel0 = 4'd5; #1;
    checks++; if (r0 !== 8'h08) begin errors++; $display("FAIL m0_lock_ready got %h want 08", r0); end
    step();
    checks++; if (oid0 !== 4'd3) begin errors++; $display("FAIL m0_lock_b2 got id%0d want id3", oid0); end
    l0 = 8'hFF;
    step();
    checks++; if (oid0 !== 4'd3 || ol0 !== 1'b1)
      begin errors++; $display("FAIL m0_lock_b3 got id%0d l%b want id3 l1", oid0, ol0); end
    step();
    checks++; if (oid0 !== 4'd5) begin errors++; $display("FAIL m0_unlock got id%0d want id5", oid0); end
    // Round-robin instance: pointer is 2; one beat from channel 0 moves it to 1.
    v1 = 8'h01;
    step();
    checks++; if (oid1 !== 3'd0) begin errors++; $display("FAIL rr_last_pre got id%0d want id0", oid1); end
    v1 = 8'h03; l1 = 8'hFD;
    for (int k = 0; k < 3; k++) begin
      if (k == 2) l1 = 8'hFE;
      step();
      checks++; if (oid1 !== 3'd1 || ol1 !== (k == 2))
        begin errors++; $display("FAIL rr_pkt_beat[%0d] got id%0d l%b want id1 l%0d", k, oid1, ol1, k == 2); end
    end
    step();
    checks++; if (oid1 !== 3'd0 || ol1 !== 1'b0)
      begin errors++; $display("FAIL rr_pkt_after got id%0d l%b want id0 l0", oid1, ol1); end
  endtask
`endif

  initial begin
    for (int i = 0; i < 8; i++) begin
      d0[i*32 +: 32] = 32'hA0 + 32'(i);
      d1[i*32 +: 32] = 32'hB0 + 32'(i);
    end
`ifdef STREAM_MUX_ARB_LAST_EN
    l0 = 8'hFF; l1 = 8'hFF;
`endif
    test_reset();
    test_mode0();
    test_fairness();
    test_backpressure();
    test_bubble();
`ifdef STREAM_MUX_ARB_LAST_EN
    test_last();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/stream_mux_arb.md
Name: stream_mux_arb

Overview:
- Parametrised N-channel, WIDTH-bit stream multiplexer with valid/ready handshakes and a registered output stage.
- Generalises the fixed 8:1 32-bit combinational select to any channel count and width.
- Two modes: external select or round-robin arbitration.
- Sits between multiple producer streams and one consumer, for example in bus/peripheral data paths.

Parameters:
- WIDTH, 32, data bits per channel.
- N, 8, number of input channels; must be ≥ 2.
- SEL_W, 3, select/ID width; 2^SEL_W ≥ N is required.
- MODE, 0, 0 = fixed select via sel, 1 = round-robin arbitration (sel ignored).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- sel  input  SEL_W  channel select, used only in MODE 0.
- in_valid  input  N  per-channel valid; bit i belongs to channel i.
- in_ready  output  N  per-channel ready.
- in_data  input  N*WIDTH  flattened data; channel i occupies bits [i*WIDTH +: WIDTH].
- out_valid  output  1  output beat valid.
- out_ready  input  1  consumer ready.
- out_data  output  WIDTH  registered output data.
- out_id  output  SEL_W  source channel of the current out_data.

Behaviour:
- Reset (rst = 1 at a clk edge): out_valid = 0, out_data = 0, out_id = 0, RR pointer = 0, lock state cleared. The reset takes priority over any transfer in that cycle.
- load = !out_valid || out_ready. The output register accepts a new beat only when load = 1.
- Grant selection, evaluated combinationally each cycle:
  - MODE 0: grant = sel when sel < N. When sel ≥ N, no channel is granted.
  - MODE 1: grant = the first channel with in_valid set, searching from the pointer upward and wrapping modulo N. When no channel has in_valid set, there is no grant.
- in_ready[i] = load && (grant == i). All other in_ready bits are 0. Only one bit of in_ready is ever high.
- Input transfer on channel g: in_valid[g] && in_ready[g].
  - Next edge: out_data = in_data of channel g, out_id = g, out_valid = 1.
  - MODE 1 only: pointer = (g + 1) mod N.
- When load = 1 and no transfer occurs, out_valid goes to 0 at the next edge. out_data and out_id hold their previous values.
- When out_valid = 1 and out_ready = 0: out_data and out_id hold stable, and all in_ready bits are 0.
- Latency: one cycle from input transfer to out_valid. Sustained throughput is one beat per cycle when out_ready is held at 1.
- In MODE 1 the pointer does not move on cycles without a transfer. Ungranted channels keep their data; the block never drops or duplicates a beat.
- In MODE 0, sel may change on any cycle. The change takes effect combinationally in the same cycle.
- When rst is asserted mid-stream, any held output beat is discarded. Upstream still owns its unaccepted beats.

Optional Feature:
- Macro: STREAM_MUX_ARB_LAST_EN.
- Defined:
  - Adds ports in_last (input, N) and out_last (output, 1, registered with the data; reset value 0).
  - After the block accepts a beat with in_last = 0 from channel g, it locks onto g. Grant is then forced to g, and sel and arbitration are ignored, until the block accepts a beat from g with in_last = 1.
  - The lock clears on that last transfer. In MODE 1 the pointer advances only on the last beat of a packet.
  - rst clears the lock.
- Undefined: neither port exists. Every beat is arbitrated independently.

Test Plan:
- Reset: hold rst for 2 cycles with all in_valid = 1 → out_valid = 0, out_data = 0, out_id = 0, in_ready = 0.
- MODE 0: sel = 5, in_valid = 8'hFF, channel i data = 32'hA0+i, out_ready = 1 → in_ready = 8'h20. One cycle later: out_data = 32'hA5, out_id = 5. Then set sel = 9 with SEL_W = 4 → no transfer, and out_valid drops after 1 cycle.
- MODE 1 fairness: all in_valid = 1, out_ready = 1 → out_id sequence 0,1,…,7,0,1 on consecutive cycles. With only channels 2 and 6 valid → 2,6,2,6.
- Backpressure: with out_valid = 1, hold out_ready = 0 for 4 cycles → out_data/out_id stable, in_ready = 0, and the pointer does not move. Release → the next grant follows the pointer, with no loss or duplication.
- Bubble: in MODE 1, drop all in_valid for 3 cycles → out_valid = 0 after the drain. The pointer keeps its value, and the first grant afterwards comes from the pointer position.
- LAST_EN: channel 1 sends a 3-beat packet (last on beat 3) while channel 0 stays valid → out_id = 1,1,1 then 0, with out_last = 1 only on the third beat.
